// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo
//   Captures each completed TDC measurement (busy falling edge) into an
//   8-deep FIFO so firmware can read back-to-back results over SPI.
//   Pops are requested by flipping a config-register toggle bit.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global enable; all state holds while low
//   busy                TDC busy flag (clk domain); falling edge = push
//   coarse_result       coarse count, sampled in the push cycle
//   fine_result         fine delay-line code, sampled in the push cycle
//   pop_toggle          each level change requests one pop
//   clear               synchronous flush of FIFO and counters
//   head_coarse/fine    oldest entry, 0 when empty
//   count, empty, full  fill level and flags
//   ovf_cnt             saturating count of results dropped while full
//
// Optional feature (macro TDC_RES_FIFO_TSTAMP_EN)
//   Adds a free-running 16-bit cycle counter stored with each entry and
//   the output head_tstamp (counter value in the push cycle, 0 when empty).

module tdc_result_fifo #(
    parameter int ADDR_W   = 3,
    parameter int COARSE_W = 32,
    parameter int FINE_W   = 9,
    parameter int OVF_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                busy,
    input  logic [COARSE_W-1:0] coarse_result,
    input  logic [FINE_W-1:0]   fine_result,
    input  logic                pop_toggle,
    input  logic                clear,
    output logic [COARSE_W-1:0] head_coarse,
    output logic [FINE_W-1:0]   head_fine,
    output logic [ADDR_W:0]     count,
    output logic                empty,
    output logic                full,
    output logic [OVF_W-1:0]    ovf_cnt
`ifdef TDC_RES_FIFO_TSTAMP_EN
    ,
    output logic [15:0]         head_tstamp
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W:0]     cnt;
    logic [OVF_W-1:0]    ovf;
    logic                busy_q, pop_q;
    logic                push, pop, do_push, do_pop, drop;

    logic [COARSE_W-1:0] mem_coarse [DEPTH];
    logic [FINE_W-1:0]   mem_fine   [DEPTH];

    assign push = ena & busy_q & ~busy;
    assign pop  = ena & (pop_toggle ^ pop_q);

    assign empty = (cnt == '0);
    assign full  = (cnt == (ADDR_W+1)'(DEPTH));

    // A pop while empty is ignored. A pop at full frees a slot in the same
    // cycle, so a coincident push is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= '0;
            busy_q <= 1'b0;
            pop_q  <= 1'b0;
        end else if (ena) begin
            // Edge detectors update even during clear, so a toggle seen
            // during clear is consumed rather than popping afterwards.
            busy_q <= busy;
            pop_q  <= pop_toggle;
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                ovf    <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                if (drop && (ovf != '1)) ovf <= ovf + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; head outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_coarse[wr_ptr] <= coarse_result;
            mem_fine[wr_ptr]   <= fine_result;
        end
    end

    assign head_coarse = empty ? '0 : mem_coarse[rd_ptr];
    assign head_fine   = empty ? '0 : mem_fine[rd_ptr];
    assign count       = cnt;
    assign ovf_cnt     = ovf;

`ifdef TDC_RES_FIFO_TSTAMP_EN
    logic [15:0] tstamp;
    logic [15:0] mem_tstamp [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     tstamp <= '0;
        else if (ena)   tstamp <= clear ? '0 : tstamp + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_tstamp[wr_ptr] <= tstamp;
    end

    assign head_tstamp = empty ? '0 : mem_tstamp[rd_ptr];
`endif

endmodule

// File: tb/tb_tdc_result_fifo.sv
// Testbench for tdc_result_fifo: directed steps from the test plan followed
// by a randomized phase, all checked against a queue-based reference model.
module tb_tdc_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        busy = 1'b0;
    logic [31:0] coarse_result = '0;
    logic [8:0]  fine_result = '0;
    logic        pop_toggle = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] head_coarse;
    logic [8:0]  head_fine;
    logic [3:0]  count;
    logic        empty, full;
    logic [7:0]  ovf_cnt;
`ifdef TDC_RES_FIFO_TSTAMP_EN
    logic [15:0] head_tstamp;
`endif

    tdc_result_fifo dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .busy(busy),
        .coarse_result(coarse_result), .fine_result(fine_result),
        .pop_toggle(pop_toggle), .clear(clear),
        .head_coarse(head_coarse), .head_fine(head_fine),
        .count(count), .empty(empty), .full(full), .ovf_cnt(ovf_cnt)
`ifdef TDC_RES_FIFO_TSTAMP_EN
        , .head_tstamp(head_tstamp)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue of measurements plus edge memories.
    typedef struct {
        logic [31:0] c;
        logic [8:0]  f;
        logic [15:0] t;
    } ent_t;

    ent_t        q[$];
    int          m_ovf;
    logic        m_bprev, m_tprev;
    logic [15:0] m_ts;
    int          tests = 0;
    int          fails = 0;

    task automatic model_reset();
        q.delete();
        m_ovf   = 0;
        m_bprev = 1'b0;
        m_tprev = 1'b0;
        m_ts    = '0;
    endtask

    // Apply the current inputs to the model, then advance one clock and
    // return at the falling edge where outputs are sampled.
    task automatic tick();
        ent_t e;
        if (ena) begin
            if (clear) begin
                q.delete();
                m_ovf = 0;
            end else begin
                if ((pop_toggle != m_tprev) && q.size() > 0) void'(q.pop_front());
                if (m_bprev && !busy) begin
                    if (q.size() < 8) begin
                        e.c = coarse_result; e.f = fine_result; e.t = m_ts;
                        q.push_back(e);
                    end else if (m_ovf < 255) begin
                        m_ovf++;
                    end
                end
            end
            m_ts    = clear ? 16'd0 : m_ts + 16'd1;
            m_bprev = busy;
            m_tprev = pop_toggle;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
        chk({tag, ".full"},  64'(full),  64'(q.size() == 8));
        chk({tag, ".ovf"},   64'(ovf_cnt), 64'(m_ovf));
        chk({tag, ".hc"},    64'(head_coarse), q.size() ? 64'(q[0].c) : 64'd0);
        chk({tag, ".hf"},    64'(head_fine),   q.size() ? 64'(q[0].f) : 64'd0);
`ifdef TDC_RES_FIFO_TSTAMP_EN
        chk({tag, ".ht"},    64'(head_tstamp), q.size() ? 64'(q[0].t) : 64'd0);
`endif
    endtask

    task automatic push_one(logic [31:0] c, logic [8:0] f);
        busy = 1'b1;
        tick();
        busy = 1'b0; coarse_result = c; fine_result = f;
        tick();
    endtask

    task automatic pop_one();
        pop_toggle = ~pop_toggle;
        tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.empty_k", 64'(empty), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single push then pop
        push_one(32'h0000_1234, 9'h0A5);
        check_all("single");
        chk("single.hc_k", 64'(head_coarse), 64'h1234);
        chk("single.hf_k", 64'(head_fine), 64'h0A5);
        pop_one();
        check_all("pop");
        chk("pop.empty_k", 64'(empty), 64'd1);
        pop_one();
        check_all("pop_empty");
        chk("pop_empty.ovf_k", 64'(ovf_cnt), 64'd0);

        // Fill and overflow, then drain in order
        for (int i = 1; i <= 10; i++) push_one(32'(i), 9'(i * 3));
        check_all("fill");
        chk("fill.cnt_k", 64'(count), 64'd8);
        chk("fill.ovf_k", 64'(ovf_cnt), 64'd2);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.hc_k", 64'(head_coarse), 64'(i));
            pop_one();
        end
        check_all("drained");
        // Second fill exercises pointer wrap
        for (int i = 11; i <= 18; i++) push_one(32'(i), 9'(i));
        check_all("wrapfill");
        for (int i = 0; i < 8; i++) begin
            check_all("wrapdrain");
            pop_one();
        end

        // Simultaneous push+pop at full
        clear = 1'b1; tick(); clear = 1'b0;
        check_all("clear1");
        for (int i = 1; i <= 8; i++) push_one(32'(i), 9'(i));
        busy = 1'b1; tick();
        busy = 1'b0; coarse_result = 32'd9; fine_result = 9'd9;
        pop_toggle = ~pop_toggle;
        tick();
        check_all("pushpop_full");
        chk("pushpop_full.cnt_k", 64'(count), 64'd8);
        chk("pushpop_full.ovf_k", 64'(ovf_cnt), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            chk("pushpop_full.hc_k", 64'(head_coarse), 64'(i));
            pop_one();
        end

        // Overflow saturation, then clear
        for (int i = 0; i < 8; i++) push_one(32'(100 + i), 9'(i));
        for (int i = 0; i < 300; i++) push_one(32'hDEAD, 9'h1FF);
        check_all("sat");
        chk("sat.ovf_k", 64'(ovf_cnt), 64'hFF);
        clear = 1'b1; pop_toggle = ~pop_toggle; tick(); clear = 1'b0;
        check_all("clear2");
        chk("clear2.ovf_k", 64'(ovf_cnt), 64'd0);
        tick();
        check_all("post_clear");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ena           = ($urandom_range(0, 7) != 0);
            busy          = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 2) == 0) pop_toggle = ~pop_toggle;
            clear         = ($urandom_range(0, 59) == 0);
            coarse_result = $urandom;
            fine_result   = 9'($urandom);
            tick();
            check_all("rand");
        end
        ena = 1'b1; clear = 1'b0;

        // Reset asserted mid-measurement, asynchronously
        for (int i = 0; i < 3; i++) push_one(32'(200 + i), 9'(i));
        busy = 1'b1; tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        chk("async_rst.cnt_k", 64'(count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pop_toggle = 1'b0;
        tick();
        busy = 1'b0; coarse_result = 32'h55; fine_result = 9'h33;
        tick();
        check_all("after_rst");
        chk("after_rst.cnt_k", 64'(count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
